// File: rtl/ex_mem_latch.sv
// ============================================================================
// Module      : ex_mem_latch
// Description : EX/MEM pipeline register with stall/flush, precise overflow
//               exception capture, halt tracking and EX forwarding outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_latch #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_alu_rslt,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_carry,
  input  logic                  i_alu_ovfl,
  input  logic                  i_ovfl_check,
  input  logic [DATA_W-1:0]     i_store_data,
  input  logic [REG_ADDR_W-1:0] i_wb_reg_addr,
  input  logic [DATA_W-1:0]     i_pc,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic                  i_halt,
  input  logic [1:0]            i_mem_width,
  input  logic                  i_mem_signed,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_exc_ack,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_alu_rslt,
  output logic                  o_alu_zero,
  output logic                  o_alu_carry,
  output logic [DATA_W-1:0]     o_store_data,
  output logic [REG_ADDR_W-1:0] o_wb_reg_addr,
  output logic [DATA_W-1:0]     o_pc,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_reg_write,
  output logic                  o_mem_to_reg,
  output logic [1:0]            o_mem_width,
  output logic                  o_mem_signed,
  output logic                  o_exception,
  output logic [DATA_W-1:0]     o_epc,
  output logic                  o_exc_pending,
  output logic                  o_halted,
  output logic                  o_fwd_en,
  output logic [DATA_W-1:0]     o_fwd_data,
  output logic                  o_load_hazard
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EXC    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_bubble;
  logic                  w_capture;
  logic                  w_fault;

  logic                  r_valid;
  logic [DATA_W-1:0]     r_alu_rslt;
  logic                  r_alu_zero;
  logic                  r_alu_carry;
  logic [DATA_W-1:0]     r_store_data;
  logic [REG_ADDR_W-1:0] r_wb_reg_addr;
  logic [DATA_W-1:0]     r_pc;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_reg_write;
  logic                  r_mem_to_reg;
  logic [1:0]            r_mem_width;
  logic                  r_mem_signed;
  logic                  r_exception;
  logic [DATA_W-1:0]     r_epc;

  // A stalled edge neither loads nor moves the FSM, except that an
  // exception acknowledge is honoured even while MEM is busy.
  always_comb begin
    w_state_nxt = r_state;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    w_fault     = 1'b0;
    if (i_stall) begin
      if (r_state == ST_EXC && i_exc_ack) w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_flush || !i_valid) begin
            w_bubble = 1'b1;
          end else begin
            w_capture = 1'b1;
            if (i_ovfl_check && i_alu_ovfl) begin
              w_fault     = 1'b1;
              w_state_nxt = ST_EXC;
            end else if (i_halt) begin
              w_state_nxt = ST_HALTED;
            end
          end
        end
        ST_EXC: begin
          w_bubble = 1'b1;
          if (i_exc_ack) w_state_nxt = ST_RUN;
        end
        ST_HALTED: w_bubble = 1'b1;
        default: begin
          w_bubble    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_alu_rslt    <= '0;
      r_alu_zero    <= 1'b0;
      r_alu_carry   <= 1'b0;
      r_store_data  <= '0;
      r_wb_reg_addr <= '0;
      r_pc          <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_mem_width   <= 2'b00;
      r_mem_signed  <= 1'b0;
      r_exception   <= 1'b0;
      r_epc         <= '0;
    end else if (w_bubble) begin
      // Bubbles kill only the side-effecting controls; data fields hold.
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_exception  <= 1'b0;
    end else if (w_capture) begin
      r_valid       <= 1'b1;
      r_alu_rslt    <= i_alu_rslt;
      r_alu_zero    <= i_alu_zero;
      r_alu_carry   <= i_alu_carry;
      r_store_data  <= i_store_data;
      r_wb_reg_addr <= i_wb_reg_addr;
      r_pc          <= i_pc;
      r_mem_read    <= i_mem_read  & ~w_fault;
      r_mem_write   <= i_mem_write & ~w_fault;
      r_reg_write   <= i_reg_write & ~w_fault;
      r_mem_to_reg  <= i_mem_to_reg;
      r_mem_width   <= i_mem_width;
      r_mem_signed  <= i_mem_signed;
      r_exception   <= w_fault;
      if (w_fault) r_epc <= i_pc;
    end
  end

  assign o_valid       = r_valid;
  assign o_alu_rslt    = r_alu_rslt;
  assign o_alu_zero    = r_alu_zero;
  assign o_alu_carry   = r_alu_carry;
  assign o_store_data  = r_store_data;
  assign o_wb_reg_addr = r_wb_reg_addr;
  assign o_pc          = r_pc;
  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_reg_write   = r_reg_write;
  assign o_mem_to_reg  = r_mem_to_reg;
  assign o_mem_width   = r_mem_width;
  assign o_mem_signed  = r_mem_signed;
  assign o_exception   = r_exception;
  assign o_epc         = r_epc;
  assign o_exc_pending = (r_state == ST_EXC);
  assign o_halted      = (r_state == ST_HALTED);
  assign o_fwd_data    = r_alu_rslt;

  // r0 is hardwired zero, so it is never a forwarding or hazard target.
  assign o_fwd_en      = r_valid & r_reg_write & ~r_mem_to_reg & (r_wb_reg_addr != '0);
  assign o_load_hazard = r_valid & r_reg_write &  r_mem_to_reg & (r_wb_reg_addr != '0);

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_latch.sv
// ============================================================================
// Module      : tb_ex_mem_latch
// Description : Directed vector bench for the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_latch;

  localparam logic [31:0] C_SD_XOR = 32'hA5A5A5A5;
  localparam int          C_NVEC   = 21;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_alu_zero = 1'b0, i_alu_carry = 1'b0, i_alu_ovfl = 1'b0;
  logic        i_ovfl_check = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0, i_reg_write = 1'b0;
  logic        i_mem_to_reg = 1'b0, i_halt = 1'b0, i_mem_signed = 1'b0;
  logic        i_stall = 1'b0, i_flush = 1'b0, i_exc_ack = 1'b0;
  logic [1:0]  i_mem_width = 2'b00;
  logic [31:0] i_alu_rslt = '0, i_store_data = '0, i_pc = '0;
  logic [4:0]  i_wb_reg_addr = '0;

  logic        o_valid, o_alu_zero, o_alu_carry, o_mem_read, o_mem_write, o_reg_write;
  logic        o_mem_to_reg, o_mem_signed, o_exception, o_exc_pending, o_halted;
  logic        o_fwd_en, o_load_hazard;
  logic [1:0]  o_mem_width;
  logic [31:0] o_alu_rslt, o_store_data, o_pc, o_epc, o_fwd_data;
  logic [4:0]  o_wb_reg_addr;

  int n_chk = 0;
  int n_fail = 0;

  ex_mem_latch #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_alu_rslt(i_alu_rslt),
    .i_alu_zero(i_alu_zero), .i_alu_carry(i_alu_carry), .i_alu_ovfl(i_alu_ovfl),
    .i_ovfl_check(i_ovfl_check), .i_store_data(i_store_data), .i_wb_reg_addr(i_wb_reg_addr),
    .i_pc(i_pc), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_halt(i_halt), .i_mem_width(i_mem_width),
    .i_mem_signed(i_mem_signed), .i_stall(i_stall), .i_flush(i_flush), .i_exc_ack(i_exc_ack),
    .o_valid(o_valid), .o_alu_rslt(o_alu_rslt), .o_alu_zero(o_alu_zero),
    .o_alu_carry(o_alu_carry), .o_store_data(o_store_data), .o_wb_reg_addr(o_wb_reg_addr),
    .o_pc(o_pc), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_mem_width(o_mem_width), .o_mem_signed(o_mem_signed),
    .o_exception(o_exception), .o_epc(o_epc), .o_exc_pending(o_exc_pending),
    .o_halted(o_halted), .o_fwd_en(o_fwd_en), .o_fwd_data(o_fwd_data),
    .o_load_hazard(o_load_hazard)
  );

  always #5 clk = ~clk;

  // ctl: {valid, ovfl, ovfl_check, reg_write, mem_read, mem_write, mem_to_reg, halt, stall, flush, ack}
  // e  : {valid, reg_write, mem_read, mem_write, mem_to_reg, exception, exc_pending, halted, fwd_en, load_hazard}
  typedef struct {
    logic [10:0] ctl;
    logic [4:0]  addr;
    logic [31:0] rslt;
    logic [31:0] pc;
    logic [9:0]  e;
    logic [4:0]  e_addr;
    logic [31:0] e_rslt;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs [C_NVEC];

  function automatic vec_t mk(logic [10:0] c, logic [4:0] a, logic [31:0] r, logic [31:0] p,
                              logic [9:0] e, logic [4:0] ea, logic [31:0] er, logic [31:0] ep,
                              logic [31:0] eepc);
    vec_t v;
    v.ctl = c; v.addr = a; v.rslt = r; v.pc = p;
    v.e = e; v.e_addr = ea; v.e_rslt = er; v.e_pc = ep; v.e_epc = eepc;
    return v;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  // Data-side side-band inputs are derived from the result so their expected
  // outputs follow from the expected result alone.
  task automatic drive(input logic [10:0] c, input logic [4:0] a, input logic [31:0] r, input logic [31:0] p);
    {i_valid, i_alu_ovfl, i_ovfl_check, i_reg_write, i_mem_read, i_mem_write,
     i_mem_to_reg, i_halt, i_stall, i_flush, i_exc_ack} = c;
    i_wb_reg_addr = a;
    i_alu_rslt    = r;
    i_pc          = p;
    i_store_data  = r ^ C_SD_XOR;
    i_alu_zero    = (r == 32'h0);
    i_alu_carry   = r[0];
    i_mem_width   = r[1:0];
    i_mem_signed  = r[2];
  endtask

  task automatic check(input string nm, input logic [9:0] e, input logic [4:0] ea,
                       input logic [31:0] er, input logic [31:0] ep, input logic [31:0] eepc);
    cmp(nm, "ctl", {22'h0, o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                    o_exception, o_exc_pending, o_halted, o_fwd_en, o_load_hazard}, {22'h0, e});
    cmp(nm, "addr", {27'h0, o_wb_reg_addr}, {27'h0, ea});
    cmp(nm, "rslt", o_alu_rslt, er);
    cmp(nm, "fwd_data", o_fwd_data, er);
    cmp(nm, "pc", o_pc, ep);
    cmp(nm, "epc", o_epc, eepc);
    if (er == 32'h0 && ea == 5'd0 && ep == 32'h0) begin
      cmp(nm, "store_data", o_store_data, 32'h0);
      cmp(nm, "side", {27'h0, o_alu_zero, o_alu_carry, o_mem_width, o_mem_signed}, 32'h0);
    end else begin
      cmp(nm, "store_data", o_store_data, er ^ C_SD_XOR);
      cmp(nm, "side", {27'h0, o_alu_zero, o_alu_carry, o_mem_width, o_mem_signed},
          {27'h0, (er == 32'h0), er[0], er[1:0], er[2]});
    end
  endtask

  initial begin
    vecs[0]  = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd3, 32'h11, 32'h10, 10'b1_1_0_0_0_0_0_0_1_0, 5'd3, 32'h11, 32'h10, 32'h0);
    vecs[1]  = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd0, 32'h22, 32'h14, 10'b1_1_0_0_0_0_0_0_0_0, 5'd0, 32'h22, 32'h14, 32'h0);
    vecs[2]  = mk(11'b1_0_0_1_1_0_1_0_0_0_0, 5'd5, 32'h1000, 32'h18, 10'b1_1_1_0_1_0_0_0_0_1, 5'd5, 32'h1000, 32'h18, 32'h0);
    vecs[3]  = mk(11'b1_0_0_0_0_1_0_0_0_0_0, 5'd7, 32'h2000, 32'h1C, 10'b1_0_0_1_0_0_0_0_0_0, 5'd7, 32'h2000, 32'h1C, 32'h0);
    vecs[4]  = mk(11'b0_1_1_1_0_0_0_1_0_0_0, 5'd9, 32'h3333, 32'h20, 10'b0, 5'd7, 32'h2000, 32'h1C, 32'h0);
    vecs[5]  = mk(11'b1_1_1_1_0_0_0_0_0_1_0, 5'd4, 32'h80000000, 32'h24, 10'b0, 5'd7, 32'h2000, 32'h1C, 32'h0);
    vecs[6]  = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd6, 32'h1234, 32'h28, 10'b1_1_0_0_0_0_0_0_1_0, 5'd6, 32'h1234, 32'h28, 32'h0);
    vecs[7]  = mk(11'b1_0_0_1_0_0_0_0_1_0_0, 5'd8, 32'hFFFF, 32'h2C, 10'b1_1_0_0_0_0_0_0_1_0, 5'd6, 32'h1234, 32'h28, 32'h0);
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd8, 32'hFFFF, 32'h2C, 10'b1_1_0_0_0_0_0_0_1_0, 5'd8, 32'hFFFF, 32'h2C, 32'h0);
    vecs[11] = mk(11'b1_1_1_1_0_0_0_0_0_0_0, 5'd2, 32'h80000000, 32'h40, 10'b1_0_0_0_0_1_1_0_0_0, 5'd2, 32'h80000000, 32'h40, 32'h40);
    vecs[12] = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd3, 32'h55, 32'h44, 10'b0_0_0_0_0_0_1_0_0_0, 5'd2, 32'h80000000, 32'h40, 32'h40);
    vecs[13] = vecs[12];
    vecs[14] = vecs[12];
    vecs[15] = mk(11'b1_0_0_1_0_0_0_0_1_0_1, 5'd3, 32'h55, 32'h44, 10'b0, 5'd2, 32'h80000000, 32'h40, 32'h40);
    vecs[16] = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd3, 32'h55, 32'h44, 10'b1_1_0_0_0_0_0_0_1_0, 5'd3, 32'h55, 32'h44, 32'h40);
    vecs[17] = mk(11'b1_0_0_1_0_0_0_0_0_0_1, 5'd4, 32'h66, 32'h48, 10'b1_1_0_0_0_0_0_0_1_0, 5'd4, 32'h66, 32'h48, 32'h40);
    vecs[18] = mk(11'b1_1_1_1_1_1_0_1_0_0_0, 5'd1, 32'h77, 32'h4C, 10'b1_0_0_0_0_1_1_0_0_0, 5'd1, 32'h77, 32'h4C, 32'h4C);
    vecs[19] = mk(11'b1_0_0_1_0_0_0_0_0_0_1, 5'd1, 32'h88, 32'h50, 10'b0, 5'd1, 32'h77, 32'h4C, 32'h4C);
    vecs[20] = mk(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd1, 32'h88, 32'h50, 10'b1_1_0_0_0_0_0_0_1_0, 5'd1, 32'h88, 32'h50, 32'h4C);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1 check("reset_init", 10'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_bubble", 10'b0, 5'd0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < C_NVEC; i++) begin
      drive(vecs[i].ctl, vecs[i].addr, vecs[i].rslt, vecs[i].pc);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].e, vecs[i].e_addr, vecs[i].e_rslt, vecs[i].e_pc, vecs[i].e_epc);
    end

    // Asynchronous reset mid-cycle while a valid entry (and nonzero EPC) is held
    #2 rst_n = 1'b0;
    #1 check("reset_async", 10'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Halt entry is held one cycle, then bubbles forever
    drive(11'b1_0_0_1_0_0_0_1_0_0_0, 5'd10, 32'h99, 32'h60);
    @(posedge clk);
    #1 check("halt_entry", 10'b1_1_0_0_0_0_0_1_1_0, 5'd10, 32'h99, 32'h60, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(11'b1_0_0_1_0_0_0_0_0_0_1, 5'd11, 32'hAB + k, 32'h64 + 4 * k);
      @(posedge clk);
      #1 check($sformatf("halted%0d", k), 10'b0_0_0_0_0_0_0_1_0_0, 5'd10, 32'h99, 32'h60, 32'h0);
    end

    // Reset is the only exit from HALTED
    #2 rst_n = 1'b0;
    #1 check("halt_reset", 10'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    drive(11'b1_0_0_1_0_0_0_0_0_0_0, 5'd12, 32'hC0, 32'h70);
    @(posedge clk);
    #1 check("post_halt_run", 10'b1_1_0_0_0_0_0_0_1_0, 5'd12, 32'hC0, 32'h70, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
